lru_n_way_cache: RTL and testbench
==================================

# lru_n_way_cache

Set-associative cache with true-LRU replacement, parametrised in data width, depth, associativity and address width. It is the successor to the two-way-default cache in the memory-side path. It adds age-based victim selection, eviction reporting for a downstream write-back buffer, and a multi-cycle flush sequencer. One registered read port and one write port share the tag/data/age arrays.

## Interface
- DATA_WIDTH, 8, data word width.
- ENTRIES, 16, total lines; multiple of WAYS; ENTRIES/WAYS a power of two, at least 2.
- WAYS, 4, associativity; power of two, at least 2.
- ADDR_WIDTH, 8, address width; must exceed log2(SETS).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-low (rst=0 resets on the next rising edge).
- re  in  1  read request.
- read_addr  in  ADDR_WIDTH  read address; set = low SET_WIDTH bits, tag = rest.
- we  in  1  write request.
- write_addr  in  ADDR_WIDTH  write address.
- in  in  DATA_WIDTH  write data.
- flush  in  1  single-cycle request to invalidate the whole cache.
- out  out  DATA_WIDTH  read data, registered.
- hit  out  1  read hit, registered.
- busy  out  1  flush in progress.
- evict_valid  out  1  one-cycle pulse: a valid line was displaced.
- evict_addr  out  ADDR_WIDTH  {victim tag, set} of the displaced line.
- evict_data  out  DATA_WIDTH  data of the displaced line.

## Operation
- Per way per set: valid bit, tag, data, age (AGE_WIDTH = log2(WAYS)). Within a set, ages are always a permutation of 0..WAYS-1. Age WAYS-1 is MRU; age 0 is LRU.
- Reset and flush-set initialisation: valid=0, age of way i = i.
- Access to way w holding age a: w takes age WAYS-1; every way in the set with age > a is decremented. Other ways are unchanged.
- Read (re=1, not busy): tag compare across valid ways.
  - Hit: out = data, hit = 1, access that way.
  - Miss: out = 0, hit = 0, ages unchanged.
  - re=0: out = 0, hit = 0.
- Write hit (we=1, not busy): overwrite data, access that way. No eviction.
- Write miss: victim = lowest-index invalid way; if all ways are valid, victim = the way with age 0. Write tag, data and valid=1, then access the victim.
  - If the victim was valid, assert evict_valid next cycle with the old tag/set and old data.
  - Otherwise evict_valid = 0.
- Simultaneous re and we:
  - Read sees pre-write array contents (read-before-write).
  - Different sets: both age updates apply.
  - Same set: only the write's age update applies; the read's update is dropped.
- FSM with states IDLE and FLUSH.
  - IDLE→FLUSH: on flush=1 in IDLE. Set the sweep counter to 0 and busy=1 from the next cycle.
  - FLUSH: initialise set[counter] each cycle and increment the counter. After set SETS-1, return to IDLE; busy=0 on the following cycle. The sweep lasts exactly SETS cycles.
  - In FLUSH, re, we and flush are ignored: hit=0, out=0, evict_valid=0, and no array writes other than the sweep.
  - flush together with re/we in IDLE: flush wins; re/we are dropped.
- Reset mid-flush: return to IDLE and clear all arrays in the same edge.

## Timing
- Reset values: out=0, hit=0, busy=0, evict_valid=0, evict_addr=0, evict_data=0. Sweep counter = 0, state = IDLE. All valid bits = 0, ages = way index.
- Read latency 1: sampled at edge N, result valid after edge N.
- Write visible to a read sampled at the next edge.
- Eviction outputs are registered: valid the cycle after the missing write. evict_addr and evict_data hold their value when evict_valid=0.
- No backpressure; the eviction consumer must accept every pulse.

## Configuration
- CACHE_STATS_EN defined: adds outputs hit_count and miss_count, each 32 bits.
  - Counters increment on read hit or read miss respectively, for non-busy reads only, and saturate at all-ones.
  - Both clear on reset and on entry to FLUSH.
- CACHE_STATS_EN undefined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- Package cache_pkg:
  - SETS/SET_WIDTH/TAG_WIDTH/AGE_WIDTH derivation functions.
  - FSM state enum (IDLE, FLUSH).
  - Tag-compare function.
- Sub-module lru_victim_sel (combinational): WAYS valid bits plus ages in, victim way index out. It is instantiated once on the write set.
- The existing binenc encoder is reused for one-hot to index conversion.

## Test plan
- Reset, then read 0x10 → hit=0, out=0. Write 0x10=0xA5, then read 0x10 → hit=1, out=0xA5 one cycle later.
- Defaults: fill set 0 with addresses 0x00, 0x04, 0x08, 0x0C, then read 0x00 and write 0x10. Victim must be 0x04: evict_valid=1, evict_addr=0x04 with its data. A subsequent read of 0x00 must hit.
- Fill 3 of 4 ways, then write a new tag → fills the invalid way, evict_valid=0.
- Same-cycle read and write to 0x20 (old 0x11, new 0x22) → out=0x11. Next read → 0x22.
- Pulse flush with re asserted → busy=1 for exactly SETS (4) cycles, and hit=0 throughout. Afterwards every prior address misses. Apply a reset mid-sweep → busy=0 the next cycle.
- With CACHE_STATS_EN: 3 hits and 2 misses → hit_count=3, miss_count=2. Flush → both 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative LRU cache: geometry derivation,
// controller state encoding and the tag-compare helper.
package cache_pkg;

   // Widest tag the compare helper handles; callers zero-extend to this width.
   localparam int unsigned MAX_TAG_WIDTH = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } cache_state_e;

   function automatic int unsigned calc_sets(input int unsigned entries, input int unsigned ways);
      return entries / ways;
   endfunction

   function automatic int unsigned calc_set_width(input int unsigned entries, input int unsigned ways);
      return $clog2(entries / ways);
   endfunction

   function automatic int unsigned calc_tag_width(input int unsigned addr_width,
                                                  input int unsigned entries,
                                                  input int unsigned ways);
      return addr_width - calc_set_width(entries, ways);
   endfunction

   function automatic int unsigned calc_age_width(input int unsigned ways);
      return $clog2(ways);
   endfunction

   // A line matches only when it is valid and its stored tag equals the request tag.
   function automatic logic tag_match(input logic                     line_valid,
                                      input logic [MAX_TAG_WIDTH-1:0] line_tag,
                                      input logic [MAX_TAG_WIDTH-1:0] req_tag);
      return line_valid && (line_tag == req_tag);
   endfunction

endpackage

// File: rtl/binenc.sv
// One-hot to binary index encoder.
// Ports: onehot (N-bit one-hot vector), idx_c (combinational index; 0 when no bit set).
module binenc #(
   parameter int unsigned N = 4,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] onehot,
   output logic [W-1:0] idx_c
);

   // OR of the indices of set bits; exact for a one-hot input.
   always_comb begin
      idx_c = '0;
      for (int i = 0; i < N; i++) begin
         if (onehot[i]) idx_c = idx_c | W'(i);
      end
   end

endmodule

// File: rtl/lru_victim_sel.sv
// Replacement victim selection for one cache set.
// Ports: valid (per-way valid bits), ages (per-way LRU age, 0 = LRU),
//        victim_c (combinational way index to replace).
module lru_victim_sel #(
   parameter int unsigned WAYS      = 4,
   parameter int unsigned AGE_WIDTH = 2
) (
   input  logic [WAYS-1:0]                valid,
   input  logic [WAYS-1:0][AGE_WIDTH-1:0] ages,
   output logic [AGE_WIDTH-1:0]           victim_c
);

   logic [WAYS-1:0] pick;
   logic            found;

   // Lowest-index invalid way first; otherwise the way whose age is 0.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
         if (!valid[i] && !found) begin
            pick[i] = 1'b1;
            found   = 1'b1;
         end
      end
      if (!found) begin
         for (int i = 0; i < WAYS; i++) begin
            if (ages[i] == '0) pick[i] = 1'b1;
         end
      end
   end

   binenc #(.N(WAYS), .W(AGE_WIDTH)) u_enc (
      .onehot (pick),
      .idx_c  (victim_c)
   );

endmodule

// File: rtl/lru_n_way_cache.sv
// Set-associative cache with true-LRU replacement, eviction reporting and a
// multi-cycle flush sweep. Optional feature macro: CACHE_STATS_EN (adds
// saturating 32-bit hit_count / miss_count outputs).
// Ports: clk, rst (sync, active-low); re/read_addr (read request);
//        we/write_addr/in (write request); flush (invalidate request);
//        out/hit (registered read result); busy (flush sweep active);
//        evict_valid/evict_addr/evict_data (registered displaced-line report).
module lru_n_way_cache
   import cache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ENTRIES    = 16,
   parameter int unsigned WAYS       = 4,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  hit,
   output logic                  busy,
   output logic                  evict_valid,
   output logic [ADDR_WIDTH-1:0] evict_addr,
`ifdef CACHE_STATS_EN
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count,
`endif
   output logic [DATA_WIDTH-1:0] evict_data
);

   localparam int unsigned SETS      = calc_sets(ENTRIES, WAYS);
   localparam int unsigned SET_WIDTH = calc_set_width(ENTRIES, WAYS);
   localparam int unsigned TAG_WIDTH = calc_tag_width(ADDR_WIDTH, ENTRIES, WAYS);
   localparam int unsigned AGE_WIDTH = calc_age_width(WAYS);

   typedef logic [WAYS-1:0][AGE_WIDTH-1:0]  age_row_t;
   typedef logic [WAYS-1:0][TAG_WIDTH-1:0]  tag_row_t;
   typedef logic [WAYS-1:0][DATA_WIDTH-1:0] data_row_t;

   logic [WAYS-1:0] valid_mem [SETS];
   tag_row_t        tag_mem   [SETS];
   data_row_t       data_mem  [SETS];
   age_row_t        age_mem   [SETS];

   cache_state_e         state, next_state;
   logic [SET_WIDTH-1:0] sweep_cnt, next_cnt;
   logic                 sweep_en;

   // Fresh set ordering: way i holds age i.
   function automatic age_row_t init_ages();
      age_row_t res;
      for (int i = 0; i < WAYS; i++) res[i] = AGE_WIDTH'(i);
      return res;
   endfunction

   // Make 'way' MRU; ways younger than its old age shift down by one.
   function automatic age_row_t lru_touch(input age_row_t ages, input logic [AGE_WIDTH-1:0] way);
      age_row_t res;
      res = ages;
      for (int i = 0; i < WAYS; i++) begin
         if (AGE_WIDTH'(i) == way)    res[i] = AGE_WIDTH'(WAYS - 1);
         else if (ages[i] > ages[way]) res[i] = ages[i] - AGE_WIDTH'(1);
      end
      return res;
   endfunction

   // Address split
   logic [SET_WIDTH-1:0] rd_set, wr_set;
   logic [TAG_WIDTH-1:0] rd_tag, wr_tag;
   assign rd_set = read_addr[SET_WIDTH-1:0];
   assign rd_tag = read_addr[ADDR_WIDTH-1:SET_WIDTH];
   assign wr_set = write_addr[SET_WIDTH-1:0];
   assign wr_tag = write_addr[ADDR_WIDTH-1:SET_WIDTH];

   // Tag lookup on both ports
   logic [WAYS-1:0] rd_hit_vec, wr_hit_vec;
   always_comb begin
      rd_hit_vec = '0;
      wr_hit_vec = '0;
      for (int w = 0; w < WAYS; w++) begin
         rd_hit_vec[w] = tag_match(valid_mem[rd_set][w], MAX_TAG_WIDTH'(tag_mem[rd_set][w]),
                                   MAX_TAG_WIDTH'(rd_tag));
         wr_hit_vec[w] = tag_match(valid_mem[wr_set][w], MAX_TAG_WIDTH'(tag_mem[wr_set][w]),
                                   MAX_TAG_WIDTH'(wr_tag));
      end
   end

   logic                 rd_hit, wr_hit;
   logic [AGE_WIDTH-1:0] rd_way, wr_hit_way, victim_way, wr_way;
   assign rd_hit = |rd_hit_vec;
   assign wr_hit = |wr_hit_vec;

   binenc #(.N(WAYS), .W(AGE_WIDTH)) u_rd_enc (.onehot(rd_hit_vec), .idx_c(rd_way));
   binenc #(.N(WAYS), .W(AGE_WIDTH)) u_wr_enc (.onehot(wr_hit_vec), .idx_c(wr_hit_way));

   lru_victim_sel #(.WAYS(WAYS), .AGE_WIDTH(AGE_WIDTH)) u_victim (
      .valid    (valid_mem[wr_set]),
      .ages     (age_mem[wr_set]),
      .victim_c (victim_way)
   );

   assign wr_way = wr_hit ? wr_hit_way : victim_way;

   // Request qualification: flush in IDLE wins, everything is ignored in FLUSH.
   logic idle, rd_do, wr_do, flush_start, rd_age_upd, evict_now;
   assign idle        = (state == IDLE);
   assign flush_start = idle && flush;
   assign rd_do       = idle && re && !flush;
   assign wr_do       = idle && we && !flush;
   // On a same-set collision only the write's age update survives.
   assign rd_age_upd  = rd_do && rd_hit && !(wr_do && (rd_set == wr_set));
   assign evict_now   = wr_do && !wr_hit && valid_mem[wr_set][victim_way];

   age_row_t rd_ages_new, wr_ages_new;
   assign rd_ages_new = lru_touch(age_mem[rd_set], rd_way);
   assign wr_ages_new = lru_touch(age_mem[wr_set], wr_way);

   // Controller state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         sweep_cnt <= '0;
      end else begin
         state     <= next_state;
         sweep_cnt <= next_cnt;
      end
   end

   // Controller next state: one set initialised per FLUSH cycle
   always_comb begin
      next_state = state;
      next_cnt   = sweep_cnt;
      sweep_en   = 1'b0;
      case (state)
         IDLE: begin
            if (flush) begin
               next_state = FLUSH;
               next_cnt   = '0;
            end
         end
         FLUSH: begin
            sweep_en = 1'b1;
            next_cnt = sweep_cnt + SET_WIDTH'(1);
            if (sweep_cnt == SET_WIDTH'(SETS - 1)) begin
               next_state = IDLE;
               next_cnt   = '0;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Tag/data/valid/age arrays
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_mem[s] <= '0;
            tag_mem[s]   <= '0;
            data_mem[s]  <= '0;
            age_mem[s]   <= init_ages();
         end
      end else begin
         if (sweep_en) begin
            valid_mem[sweep_cnt] <= '0;
            age_mem[sweep_cnt]   <= init_ages();
         end
         if (wr_do) begin
            valid_mem[wr_set][wr_way] <= 1'b1;
            tag_mem[wr_set][wr_way]   <= wr_tag;
            data_mem[wr_set][wr_way]  <= in;
            age_mem[wr_set]           <= wr_ages_new;
         end
         if (rd_age_upd) age_mem[rd_set] <= rd_ages_new;
      end
   end

   // Registered read, busy and eviction outputs; evict address/data hold between pulses
   always_ff @(posedge clk) begin
      if (!rst) begin
         out         <= '0;
         hit         <= 1'b0;
         busy        <= 1'b0;
         evict_valid <= 1'b0;
         evict_addr  <= '0;
         evict_data  <= '0;
      end else begin
         hit         <= rd_do && rd_hit;
         out         <= (rd_do && rd_hit) ? data_mem[rd_set][rd_way] : '0;
         busy        <= (next_state == FLUSH);
         evict_valid <= evict_now;
         if (evict_now) begin
            evict_addr <= {tag_mem[wr_set][victim_way], wr_set};
            evict_data <= data_mem[wr_set][victim_way];
         end
      end
   end

`ifdef CACHE_STATS_EN
   // Saturating read statistics, cleared on reset and on flush entry
   always_ff @(posedge clk) begin
      if (!rst || flush_start) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (rd_do) begin
         if (rd_hit) begin
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
         end else begin
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lru_n_way_cache.sv
// Self-checking bench for lru_n_way_cache (default geometry: 4 sets x 4 ways).
// Driver pushes expected responses into a queue; a negedge monitor pops and compares.
module tb_lru_n_way_cache;

   logic       clk = 1'b0;
   logic       rst;
   logic       re, we, flush;
   logic [7:0] read_addr, write_addr, in;
   logic [7:0] out;
   logic       hit, busy, evict_valid;
   logic [7:0] evict_addr, evict_data;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   lru_n_way_cache #(
      .DATA_WIDTH (8),
      .ENTRIES    (16),
      .WAYS       (4),
      .ADDR_WIDTH (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .re          (re),
      .read_addr   (read_addr),
      .we          (we),
      .write_addr  (write_addr),
      .in          (in),
      .flush       (flush),
      .out         (out),
      .hit         (hit),
      .busy        (busy),
      .evict_valid (evict_valid),
      .evict_addr  (evict_addr),
`ifdef CACHE_STATS_EN
      .hit_count   (hit_count),
      .miss_count  (miss_count),
`endif
      .evict_data  (evict_data)
   );

   typedef struct {
      int          due;
      bit          c_rd;
      logic        hit;
      logic [7:0]  out;
      bit          c_ev;
      logic        ev_v;
      bit          c_ad;
      logic [7:0]  ev_a;
      logic [7:0]  ev_d;
      bit          c_busy;
      logic        busy;
      bit          c_st;
      logic [31:0] hc;
      logic [31:0] mc;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got 0x%0h, want 0x%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: compares every expectation that falls due after this cycle's edge
   always @(negedge clk) begin
      exp_t  e;
      string nm;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         cmp(nm, "cycle", 32'(cyc), 32'(e.due));
         if (e.c_rd) begin
            cmp(nm, "hit", 32'(hit), 32'(e.hit));
            cmp(nm, "out", 32'(out), 32'(e.out));
         end
         if (e.c_ev) cmp(nm, "evict_valid", 32'(evict_valid), 32'(e.ev_v));
         if (e.c_ad) begin
            cmp(nm, "evict_addr", 32'(evict_addr), 32'(e.ev_a));
            cmp(nm, "evict_data", 32'(evict_data), 32'(e.ev_d));
         end
         if (e.c_busy) cmp(nm, "busy", 32'(busy), 32'(e.busy));
`ifdef CACHE_STATS_EN
         if (e.c_st) begin
            cmp(nm, "hit_count", hit_count, e.hc);
            cmp(nm, "miss_count", miss_count, e.mc);
         end
`endif
      end
   end

   function automatic exp_t e0();
      exp_t e;
      e = '{due: 0, c_rd: 1'b0, hit: 1'b0, out: 8'h00, c_ev: 1'b0, ev_v: 1'b0, c_ad: 1'b0,
            ev_a: 8'h00, ev_d: 8'h00, c_busy: 1'b0, busy: 1'b0, c_st: 1'b0, hc: 32'd0, mc: 32'd0};
      return e;
   endfunction

   // Drive one cycle of stimulus and queue what must appear after the next edge
   task automatic op(input string nm, input exp_t e, input bit r, input logic [7:0] ra,
                     input bit w, input logic [7:0] wa, input logic [7:0] wd,
                     input bit f, input bit rs);
      re = r; read_addr = ra; we = w; write_addr = wa; in = wd; flush = f; rst = rs;
      e.due = cyc + 1;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string nm, input logic [7:0] a, input logic h, input logic [7:0] o);
      exp_t e;
      e = e0(); e.c_rd = 1'b1; e.hit = h; e.out = o;
      op(nm, e, 1'b1, a, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic wr(input string nm, input logic [7:0] a, input logic [7:0] d, input logic v,
                     input bit c_ad, input logic [7:0] ea, input logic [7:0] ed);
      exp_t e;
      e = e0(); e.c_ev = 1'b1; e.ev_v = v; e.c_ad = c_ad; e.ev_a = ea; e.ev_d = ed;
      op(nm, e, 1'b0, 8'h00, 1'b1, a, d, 1'b0, 1'b1);
   endtask

   task automatic rst_cycle(input string nm);
      exp_t e;
      e = e0(); e.c_rd = 1'b1; e.c_ev = 1'b1; e.c_ad = 1'b1; e.c_busy = 1'b1; e.c_st = 1'b1;
      op(nm, e, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   // Cycle during/around a flush: read forced to miss, busy as given
   task automatic fl(input string nm, input bit r, input bit w, input bit f, input logic b);
      exp_t e;
      e = e0(); e.c_rd = 1'b1; e.c_ev = 1'b1; e.c_busy = 1'b1; e.busy = b;
      op(nm, e, r, 8'h20, w, 8'h30, 8'h99, f, 1'b1);
   endtask

   initial begin
      exp_t e;
      rst = 1'b0; re = 1'b0; we = 1'b0; flush = 1'b0;
      read_addr = '0; write_addr = '0; in = '0;
      @(posedge clk);
      #1;

      // Reset values, cold miss, write then hit
      rst_cycle("reset0");
      rst_cycle("reset1");
      rd("rd_cold", 8'h10, 1'b0, 8'h00);
      wr("wr_10", 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
      rd("rd_10", 8'h10, 1'b1, 8'hA5);

      // Set 0 filled, 0x00 touched, so 0x04 becomes LRU and is displaced by 0x10
      rst_cycle("reset2");
      wr("fill_00", 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
      wr("fill_04", 8'h04, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00);
      wr("fill_08", 8'h08, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00);
      wr("fill_0c", 8'h0C, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00);
      rd("rd_00", 8'h00, 1'b1, 8'h01);
      wr("evict_04", 8'h10, 8'h55, 1'b1, 1'b1, 8'h04, 8'h02);
      rd("rd_00_again", 8'h00, 1'b1, 8'h01);
      rd("rd_04_gone", 8'h04, 1'b0, 8'h00);
      rd("rd_10_new", 8'h10, 1'b1, 8'h55);

      // Set 1: invalid way filled without eviction (evict payload holds), then full-set eviction
      wr("s1_01", 8'h01, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);
      wr("s1_05", 8'h05, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00);
      wr("s1_09", 8'h09, 8'h13, 1'b0, 1'b0, 8'h00, 8'h00);
      wr("s1_last_free", 8'h0D, 8'h14, 1'b0, 1'b1, 8'h04, 8'h02);
      wr("evict_01", 8'h11, 8'h15, 1'b1, 1'b1, 8'h01, 8'h11);
      wr("wr_hit_05", 8'h05, 8'h77, 1'b0, 1'b1, 8'h01, 8'h11);
      rd("rd_05", 8'h05, 1'b1, 8'h77);

      // Set 0 ages now put way2 (0x08) at LRU
      wr("evict_08", 8'h20, 8'h11, 1'b1, 1'b1, 8'h08, 8'h03);
      e = e0(); e.c_rd = 1'b1; e.hit = 1'b1; e.out = 8'h11; e.c_ev = 1'b1;
      op("rw_same_20", e, 1'b1, 8'h20, 1'b1, 8'h20, 8'h22, 1'b0, 1'b1);
      rd("rd_20_new", 8'h20, 1'b1, 8'h22);

      // Flush with re held: busy for exactly 4 cycles, writes during sweep ignored
      fl("flush_go", 1'b1, 1'b0, 1'b1, 1'b1);
      fl("flush_1", 1'b1, 1'b1, 1'b0, 1'b1);
      fl("flush_2", 1'b1, 1'b0, 1'b1, 1'b1);
      fl("flush_3", 1'b1, 1'b0, 1'b0, 1'b1);
      fl("flush_done", 1'b1, 1'b0, 1'b0, 1'b0);
      rd("post_00", 8'h00, 1'b0, 8'h00);
      rd("post_10", 8'h10, 1'b0, 8'h00);
      rd("post_20", 8'h20, 1'b0, 8'h00);
      rd("post_05", 8'h05, 1'b0, 8'h00);
      rd("post_30", 8'h30, 1'b0, 8'h00);

      // Reset in the middle of a sweep; set 3 (never swept) must still be cleared
      wr("wr_03", 8'h03, 8'h33, 1'b0, 1'b0, 8'h00, 8'h00);
      rd("rd_03", 8'h03, 1'b1, 8'h33);
      fl("mid_go", 1'b0, 1'b0, 1'b1, 1'b1);
      fl("mid_1", 1'b0, 1'b0, 1'b0, 1'b1);
      rst_cycle("reset_mid");
      fl("mid_after", 1'b0, 1'b0, 1'b0, 1'b0);
      rd("rd_03_cleared", 8'h03, 1'b0, 8'h00);

      // Statistics: 3 hits, 2 misses, then flush clears both
      rst_cycle("reset_stats");
      wr("st_wr_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
      rd("st_h1", 8'h01, 1'b1, 8'h01);
      rd("st_h2", 8'h01, 1'b1, 8'h01);
      rd("st_h3", 8'h01, 1'b1, 8'h01);
      rd("st_m1", 8'h02, 1'b0, 8'h00);
      rd("st_m2", 8'h06, 1'b0, 8'h00);
      e = e0(); e.c_st = 1'b1; e.hc = 32'd3; e.mc = 32'd2;
      op("st_counts", e, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      e = e0(); e.c_st = 1'b1; e.c_busy = 1'b1; e.busy = 1'b1;
      op("st_flush", e, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         e = e0(); e.c_busy = 1'b1; e.busy = (i < 3);
         op("st_sweep", e, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      end

      re = 1'b0; we = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp("drain", "pending", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
